uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Asynchronous serial receiver; counterpart of the existing UART transmitter on the same link.
- Frame format: 8N1, LSB first, idle-high line.
- Deserialises the incoming line into bytes and presents each on a valid/ready output (same handshake style as the transmitter's input).
- Flags framing errors and overruns; lets the board accept commands from the host PC (e.g. a remote "go" for the ultrasonic sensor).

Parameters:
- DATA_WIDTH, 8, payload bits per frame.
- CLKS_PER_BIT, 10417, clk cycles per bit (100 MHz / 9600 baud, rounded); legal range ≥ 4.

Ports:
- clk  in  1  system clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- rx  in  1  serial line from pin; asynchronous, idle high.
- data  out  DATA_WIDTH  received byte; stable while valid=1.
- valid  out  1  byte available; held until accepted.
- ready  in  1  consumer accepts data when valid&ready on a rising edge.
- frame_err  out  1  one-cycle pulse: stop bit sampled low.
- overrun  out  1  one-cycle pulse: new byte completed while previous still unaccepted.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Synchroniser: rx passes through a 2-FF synchroniser (initialised to 1 on reset); rx_s = second stage. All decisions use rx_s only.
- Reset: state=IDLE, counters=0, data=0, valid=0, frame_err=0, overrun=0, busy=0, sync FFs=1. A reset mid-frame aborts the frame; nothing is delivered.
- Bit counter: clk_cnt counts 0..CLKS_PER_BIT-1. bit_idx counts 0..DATA_WIDTH-1.
- IDLE:
  - rx_s=0 -> START, clk_cnt=0.
- START:
  - At clk_cnt = CLKS_PER_BIT/2-1 (integer division; mid start bit), sample rx_s.
  - Sample 0 -> DATA, clk_cnt=0, bit_idx=0.
  - Sample 1 -> glitch; return to IDLE, no flags.
- DATA:
  - At clk_cnt = CLKS_PER_BIT-1, sample rx_s into shift register bit bit_idx (LSB first) and reset clk_cnt.
  - After bit DATA_WIDTH-1 -> STOP.
- STOP:
  - At clk_cnt = CLKS_PER_BIT-1, sample rx_s.
  - Sample 1 -> deliver (see below), go to IDLE.
  - Sample 0 -> frame_err=1 for exactly one cycle, byte discarded, go to WAIT_HIGH.
- WAIT_HIGH:
  - Stays until rx_s=1, then IDLE. This prevents a break condition being decoded as 0x00 frames.
- Deliver, on the cycle after the stop sample:
  - valid=0, or valid=1 with ready=1 on that same edge -> data<=shift register, valid=1. A simultaneous accept and new delivery is legal; no overrun.
  - valid=1 with ready=0 -> overrun=1 for one cycle; the old data and valid are kept and the new byte is dropped.
- Handshake:
  - valid falls on the edge where valid&ready=1 (unless a simultaneous delivery occurs).
  - data must not change while valid=1 and not accepted.
  - ready while valid=0 has no effect.
- Latency: valid rises 1 clk after the stop-bit sample point, i.e. about 9.5 bit-times plus 3 clk after the falling edge of the start bit at the pin.
- Back-to-back frames: after STOP returns to IDLE (mid stop bit), a start edge is detected immediately. No idle gap is required.
- busy=0 only in IDLE. It is combinational from state or registered, with identical timing to state.

Test Plan:
- CLKS_PER_BIT=16, ready=1: send 0xA5 (8N1) -> valid pulses 1 cycle with data=0xA5; frame_err=0, overrun=0.
- CLKS_PER_BIT=16, ready=0: send 0x3C then 0x81 back-to-back -> valid=1 with data=0x3C held; one-cycle overrun at the end of the second frame; then raise ready -> data 0x3C accepted, valid=0.
- Send 0x55 with the stop bit forced to 0, then hold the line low for 40 bit-times -> one frame_err pulse; valid stays 0; no further frames until the line returns high; then 0x0F received correctly.
- Low glitch on rx lasting 5 clk (less than half a bit) while idle -> returns to IDLE; no valid, no flags; busy high only during the glitch window.
- Assert rst during bit 4 of frame 0xFF, release, then send 0x12 -> no output for the aborted frame; 0x12 received; all outputs 0 during reset.
- Baud tolerance: transmit 0xC3 with the bit period at 16±0.6 clk (±3.75%) -> data=0xC3 in both cases.

Source files
------------

// File: rtl/uart_rx_if.sv
// Byte-output port of the UART receiver: received data on a valid/ready handshake plus status pulses.
// The receiver is the master and drives data, valid, frame_err, overrun and busy; the consumer drives ready.
interface uart_rx_if #(
  parameter int DATA_WIDTH = 8
);
  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  frame_err;
  logic                  overrun;
  logic                  busy;

  modport master (
    output data, valid, frame_err, overrun, busy,
    input  ready
  );

  modport slave (
    input  data, valid, frame_err, overrun, busy,
    output ready
  );
endinterface

// File: rtl/uart_rx.sv
// 8N1-style serial receiver: 2-FF synchroniser, mid-bit sampling FSM, single-entry valid/ready output
// stage with overrun and framing-error pulses.
module uart_rx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 10417
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx,
  uart_rx_if.master   bus,
  output logic [2:0]  o_dbg_state
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DATA_WIDTH - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_START     = 3'd1;
  localparam logic [2:0] S_DATA      = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_HIGH = 3'd4;

  logic                  r_sync1;
  logic                  r_sync2;
  logic [2:0]            r_state;
  logic [CW-1:0]         r_clk_cnt;
  logic [IW-1:0]         r_bit_idx;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_deliver;
  logic [DATA_WIDTH-1:0] r_data;
  logic                  r_valid;
  logic                  r_frame_err;
  logic                  r_overrun;

  logic w_rx_s;
  logic w_cnt_last;

  assign w_rx_s     = r_sync2;
  assign w_cnt_last = (r_clk_cnt == CNT_LAST);

  // Line side: synchroniser and frame decoder. r_deliver flags a good stop bit for the output stage.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync1     <= 1'b1;
      r_sync2     <= 1'b1;
      r_state     <= S_IDLE;
      r_clk_cnt   <= '0;
      r_bit_idx   <= '0;
      r_shift     <= '0;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_sync1     <= rx;
      r_sync2     <= r_sync1;
      r_deliver   <= 1'b0;
      r_frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_clk_cnt <= '0;
          if (!w_rx_s) r_state <= S_START;
        end
        S_START: begin
          if (r_clk_cnt == CNT_HALF) begin
            r_clk_cnt <= '0;
            r_bit_idx <= '0;
            r_state   <= w_rx_s ? S_IDLE : S_DATA;
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_DATA: begin
          if (w_cnt_last) begin
            r_clk_cnt          <= '0;
            r_shift[r_bit_idx] <= w_rx_s;
            if (r_bit_idx == IDX_LAST) r_state <= S_STOP;
            else                       r_bit_idx <= r_bit_idx + IW'(1);
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_STOP: begin
          if (w_cnt_last) begin
            r_clk_cnt <= '0;
            if (w_rx_s) begin
              r_deliver <= 1'b1;
              r_state   <= S_IDLE;
            end else begin
              r_frame_err <= 1'b1;
              r_state     <= S_WAIT_HIGH;
            end
          end else begin
            r_clk_cnt <= r_clk_cnt + CW'(1);
          end
        end
        S_WAIT_HIGH: begin
          // A held-low line (break) must not be decoded as a stream of zero bytes.
          r_clk_cnt <= '0;
          if (w_rx_s) r_state <= S_IDLE;
        end
        default: begin
          r_clk_cnt <= '0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Handshake: a byte transfers on any rising edge with valid=1 and ready=1. valid stays high and data
  // stays frozen until then; ready while valid=0 is ignored. A delivery on the accepting edge reloads
  // the slot, while a delivery into an unaccepted slot is dropped and reported as overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      r_overrun <= 1'b0;
      if (r_deliver) begin
        if (!r_valid || bus.ready) begin
          r_data  <= r_shift;
          r_valid <= 1'b1;
        end else begin
          r_overrun <= 1'b1;
        end
      end else if (r_valid && bus.ready) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign bus.data      = r_data;
  assign bus.valid     = r_valid;
  assign bus.frame_err = r_frame_err;
  assign bus.overrun   = r_overrun;
  assign bus.busy      = (r_state != S_IDLE);
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_uart_rx.sv
// Directed and randomised frames driven onto rx; accepted bytes and status pulses are collected at the
// falling edge and compared against expectations derived from the frame contents and ready pattern.
`timescale 1ns/1ps
module tb_uart_rx;

  localparam int CPB   = 16;
  localparam int CLK_NS = 10;
  localparam int BIT_NS = CPB * CLK_NS;

  logic       clk;
  logic       rst;
  logic       rx;
  logic [2:0] dbg_state;

  uart_rx_if #(.DATA_WIDTH(8)) bus ();

  uart_rx #(.DATA_WIDTH(8), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .rst         (rst),
    .rx          (rx),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  initial clk = 1'b0;
  always #(CLK_NS / 2) clk = ~clk;

  int total;
  int bad;
  logic [7:0] got_q[$];
  logic [7:0] exp_q[$];
  int n_ferr;
  int n_ovr;
  int n_vcyc;
  int n_busy;
  logic       prev_hold;
  logic [7:0] prev_data;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_q(input string tag);
    chk({tag, " count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
      chk(tag, 32'(got_q[i]), 32'(exp_q[i]));
    got_q.delete();
    exp_q.delete();
  endtask

  task automatic clear_counts();
    n_ferr = 0;
    n_ovr  = 0;
    n_vcyc = 0;
    n_busy = 0;
  endtask

  // Line-level frame: start bit, 8 data bits LSB first, then the given stop level (left on the line).
  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int per_ns);
    rx = 1'b0;
    #(per_ns);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      #(per_ns);
    end
    rx = stop_bit;
    #(per_ns);
  endtask

  task automatic set_ready(input logic v);
    @(posedge clk);
    #2 bus.ready = v;
  endtask

  // Observer: records accepted bytes and pulse counts, and checks data holds while waiting for ready.
  always @(negedge clk) begin
    if (rst) begin
      prev_hold = 1'b0;
    end else begin
      if (bus.valid && bus.ready) got_q.push_back(bus.data);
      if (bus.frame_err) n_ferr++;
      if (bus.overrun)   n_ovr++;
      if (bus.valid)     n_vcyc++;
      if (bus.busy)      n_busy++;
      if (prev_hold && bus.valid) chk("data_stable", 32'(bus.data), 32'(prev_data));
      prev_hold = bus.valid && !bus.ready;
      prev_data = bus.data;
    end
  end

  initial begin
    logic [7:0] b;
    int per;
    int gap;
    total = 0;
    bad   = 0;
    prev_hold = 1'b0;
    prev_data = '0;
    clear_counts();
    rst = 1'b1;
    rx = 1'b1;
    bus.ready = 1'b0;

    // Reset state
    repeat (4) @(negedge clk);
    chk("rst_valid", 32'(bus.valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data", 32'(bus.data), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #(2 * BIT_NS);

    // Single byte with ready held high: one-cycle valid
    set_ready(1'b1);
    clear_counts();
    send_frame(8'hA5, 1'b1, BIT_NS);
    exp_q.push_back(8'hA5);
    #(2 * BIT_NS);
    check_q("a5_byte");
    chk("a5_valid_cycles", 32'(n_vcyc), 32'd1);
    chk("a5_ferr", 32'(n_ferr), 32'd0);
    chk("a5_ovr", 32'(n_ovr), 32'd0);
    chk("a5_idle", 32'(bus.busy), 32'd0);

    // Two back-to-back bytes with ready low: first is held, second overruns and is dropped
    set_ready(1'b0);
    clear_counts();
    send_frame(8'h3C, 1'b1, BIT_NS);
    send_frame(8'h81, 1'b1, BIT_NS);
    #(2 * BIT_NS);
    chk("ovr_valid_held", 32'(bus.valid), 32'd1);
    chk("ovr_data_held", 32'(bus.data), 32'h3C);
    chk("ovr_pulses", 32'(n_ovr), 32'd1);
    chk("ovr_nothing_taken", 32'(got_q.size()), 32'd0);
    set_ready(1'b1);
    exp_q.push_back(8'h3C);
    repeat (3) @(negedge clk);
    chk("ovr_valid_drop", 32'(bus.valid), 32'd0);
    check_q("ovr_accept");

    // Bad stop bit followed by a long break: one frame error, no bytes, then recovery
    clear_counts();
    send_frame(8'h55, 1'b0, BIT_NS);
    #(40 * BIT_NS);
    chk("brk_ferr", 32'(n_ferr), 32'd1);
    chk("brk_no_valid", 32'(n_vcyc), 32'd0);
    chk("brk_busy", 32'(bus.busy), 32'd1);
    rx = 1'b1;
    #(3 * BIT_NS);
    chk("brk_idle", 32'(bus.busy), 32'd0);
    send_frame(8'h0F, 1'b1, BIT_NS);
    exp_q.push_back(8'h0F);
    #(2 * BIT_NS);
    check_q("brk_recover");
    chk("brk_ferr_after", 32'(n_ferr), 32'd1);

    // Short low glitch while idle: brief busy, nothing reported
    clear_counts();
    rx = 1'b0;
    #(5 * CLK_NS);
    rx = 1'b1;
    #(3 * BIT_NS);
    chk("glitch_no_valid", 32'(n_vcyc), 32'd0);
    chk("glitch_no_ferr", 32'(n_ferr), 32'd0);
    chk("glitch_busy_short", 32'(n_busy >= 6 && n_busy <= 10), 32'd1);
    chk("glitch_idle", 32'(bus.busy), 32'd0);

    // Reset in the middle of bit 4 of 0xFF aborts it
    clear_counts();
    rx = 1'b0;
    #(BIT_NS);
    rx = 1'b1;
    #(4 * BIT_NS + BIT_NS / 2);
    @(posedge clk);
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("mid_rst_valid", 32'(bus.valid), 32'd0);
    chk("mid_rst_busy", 32'(bus.busy), 32'd0);
    chk("mid_rst_ferr", 32'(bus.frame_err), 32'd0);
    chk("mid_rst_ovr", 32'(bus.overrun), 32'd0);
    chk("mid_rst_data", 32'(bus.data), 32'd0);
    @(posedge clk);
    #2 rst = 1'b0;
    #(12 * BIT_NS);
    chk("mid_rst_no_output", 32'(got_q.size()), 32'd0);
    send_frame(8'h12, 1'b1, BIT_NS);
    exp_q.push_back(8'h12);
    #(2 * BIT_NS);
    check_q("after_rst");

    // Baud tolerance: bit period 16.6 and 15.4 clk
    send_frame(8'hC3, 1'b1, BIT_NS + 6);
    exp_q.push_back(8'hC3);
    #(2 * BIT_NS);
    send_frame(8'hC3, 1'b1, BIT_NS - 6);
    exp_q.push_back(8'hC3);
    #(2 * BIT_NS);
    check_q("baud_tol");

    // Random bytes, small period jitter, random idle gaps including back-to-back
    clear_counts();
    for (int k = 0; k < 10; k++) begin
      b   = 8'($urandom_range(0, 255));
      per = $urandom_range(BIT_NS - 3, BIT_NS + 3);
      gap = $urandom_range(0, 2);
      send_frame(b, 1'b1, per);
      exp_q.push_back(b);
      #(gap * BIT_NS);
    end
    #(2 * BIT_NS);
    check_q("random");
    chk("random_ferr", 32'(n_ferr), 32'd0);
    chk("random_ovr", 32'(n_ovr), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
